// File: rtl/song_sequencer.sv
// Tempo-timed note sequencer: steps the song ROM index and times PLAY/GAP windows.
// Optional inter-note silence is enabled with `define SONG_SEQ_GAP_EN.
module song_sequencer #(
  parameter int TICK_DIV  = 100000,
  parameter int CNT_BITS  = 8,
  parameter int FN_BITS   = 12,
  parameter int GAP_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                abort,
  input  logic [1:0]          mod,
  input  logic [CNT_BITS-1:0] track,
  input  logic [FN_BITS-1:0]  full_note,
  input  logic [2:0]          goal_length,
  output logic [CNT_BITS-1:0] cnt,
  output logic                sound_en,
  output logic                over,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_dbg
);

  localparam int DW = FN_BITS + 1;
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int TW = (GW > DW) ? GW : DW;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ONE      = TW'(1);
`ifdef SONG_SEQ_GAP_EN
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PLAY   = 3'd2,
    S_GAP    = 3'd3,
    S_PAUSED = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                state, resume_state;
  logic [1:0]            mod_q;
  logic [CNT_BITS-1:0]   track_q;
  logic [TW-1:0]         dur, ticks;
  logic [DW-1:0]         full_mod, dur_calc;
  logic [PW-1:0]         presc;
  logic [2:0]            code;
  logic                  tick;

  always_comb begin
    code = (goal_length > 3'd4) ? 3'd4 : goal_length;
    case (mod_q)
      2'b10:   full_mod = {full_note, 1'b0};
      2'b11:   full_mod = {2'b00, full_note[FN_BITS-1:1]};
      default: full_mod = {1'b0, full_note};
    endcase
    dur_calc = full_mod >> code;
    if (dur_calc == '0) dur_calc = DW'(1);
  end

  assign tick      = (presc == PRE_LAST);
  assign state_dbg = state;

  // A note ends with one extra cycle in its last timing state where `over` is high;
  // that cycle chooses between the next LOAD and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      resume_state <= S_IDLE;
      mod_q        <= '0;
      track_q      <= '0;
      dur          <= '0;
      ticks        <= '0;
      presc        <= '0;
      cnt          <= '0;
      sound_en     <= 1'b0;
      over         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      ticks    <= '0;
      presc    <= '0;
      cnt      <= '0;
      sound_en <= 1'b0;
      over     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mod_q   <= mod;
            track_q <= track;
            cnt     <= '0;
            if (track == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_LOAD;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          dur      <= TW'(dur_calc);
          presc    <= '0;
          ticks    <= '0;
          sound_en <= 1'b1;
          state    <= S_PLAY;
        end
        S_PLAY, S_GAP: begin
          if (over) begin
            over <= 1'b0;
            if (cnt == track_q) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_LOAD;
            end
          end else if (pause) begin
            resume_state <= state;
            state        <= S_PAUSED;
            sound_en     <= 1'b0;
          end else if (!tick) begin
            presc <= presc + PW'(1);
          end else begin
            presc <= '0;
            ticks <= ticks + ONE;
            if (state == S_PLAY && (ticks + ONE) == dur) begin
              ticks    <= '0;
              sound_en <= 1'b0;
`ifdef SONG_SEQ_GAP_EN
              state    <= S_GAP;
`else
              over     <= 1'b1;
              cnt      <= cnt + CNT_BITS'(1);
`endif
            end
`ifdef SONG_SEQ_GAP_EN
            else if (state == S_GAP && ticks == GAP_LAST) begin
              ticks <= '0;
              over  <= 1'b1;
              cnt   <= cnt + CNT_BITS'(1);
            end
`endif
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            state    <= resume_state;
            sound_en <= (resume_state == S_PLAY);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: per-note expectations are queued at start,
// and a negedge monitor checks each `over` pulse against them.
module tb_song_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int CNT_BITS  = 8;
  localparam int FN_BITS   = 12;
  localparam int GAP_TICKS = 2;
`ifdef SONG_SEQ_GAP_EN
  localparam int GAP_CYC = GAP_TICKS * TICK_DIV;
`else
  localparam int GAP_CYC = 0;
`endif
  // entry: {last, timed, cnt[7:0], run[19:0], period[19:0]}
  localparam int W = 50;

  logic                clk, rst, start, pause, abort;
  logic [1:0]          mod;
  logic [CNT_BITS-1:0] track;
  logic [FN_BITS-1:0]  full_note;
  logic [2:0]          goal_length;
  logic [CNT_BITS-1:0] cnt;
  logic                sound_en, over, busy, done;
  logic [2:0]          state_dbg;

  logic [2:0] rom_len [0:255];
  assign goal_length = rom_len[cnt];

  song_sequencer #(
    .TICK_DIV(TICK_DIV), .CNT_BITS(CNT_BITS), .FN_BITS(FN_BITS), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .mod(mod), .track(track), .full_note(full_note), .goal_length(goal_length),
    .cnt(cnt), .sound_en(sound_en), .over(over), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit start_ok = 0;
  bit pause_win = 0;
  bit chk_done = 0;
  logic [CNT_BITS-1:0] done_cnt;
  int since = 0, run_len = 0, last_run = 0, pause_hi = 0, pause_over = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: duration in ticks from the note rules
  function automatic int model_dur(input int full, input int m, input int len);
    int fm, c, d;
    c  = (len > 4) ? 4 : len;
    fm = (m == 2) ? full * 2 : (m == 3) ? full / 2 : full;
    d  = fm / (1 << c);
    if (d == 0) d = 1;
    return d;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    since++;
    if (sound_en) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (pause_win) begin
      if (sound_en) pause_hi++;
      if (over) pause_over++;
    end
    if (chk_done) begin
      chk_done = 0;
      chk("done_level", done, 1);
      chk("busy_after_done", busy, 0);
      chk("cnt_at_done", cnt, done_cnt);
    end
    if (over) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_over: got over=1 at cnt=%0d expected no pulse", cnt);
      end else begin
        e = exp_q.pop_front();
        chk("note_cnt", cnt, 32'(e[47:40]));
        chk("note_play_len", last_run, 32'(e[39:20]));
        if (e[48]) chk("note_period", since, 32'(e[19:0]));
        if (e[49]) begin
          chk_done = 1;
          done_cnt = e[47:40];
        end
      end
      since    = 0;
      last_run = 0;
    end
    if (start_ok) begin
      since    = 0;
      run_len  = 0;
      last_run = 0;
    end
  end

  // driver tasks
  task automatic push_song(input int trk, input int full, input int m);
    logic [W-1:0] e;
    for (int i = 0; i < trk; i++) begin
      int d;
      d = model_dur(full, m, int'(rom_len[i]));
      e = '0;
      e[49]    = (i == trk - 1);
      e[48]    = 1'b1;
      e[47:40] = CNT_BITS'(i + 1);
      e[39:20] = 20'(d * TICK_DIV);
      e[19:0]  = 20'(d * TICK_DIV + GAP_CYC + 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int trk, input int full, input int m);
    full_note = FN_BITS'(full);
    mod       = 2'(m);
    track     = CNT_BITS'(trk);
    @(posedge clk); #1;
    start = 1'b1; start_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_ok = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !chk_done) break;
    end
    chk("song_timeout_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_song(input int trk, input int full, input int m, input int poke);
    push_song(trk, full, m);
    do_start(trk, full, m);
    mod   = 2'($urandom_range(0, 3));
    track = CNT_BITS'($urandom_range(0, 5));
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_sound_en"}, sound_en, 0);
    chk({tag, "_over"}, over, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] e;
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    mod = '0; track = '0; full_note = '0;
    for (int i = 0; i < 256; i++) rom_len[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // basic two-note song
    rom_len[0] = 3'd2; rom_len[1] = 3'd3;
    run_song(2, 16, 0, 0);

    // speed mods, clamp and oversized length code
    rom_len[0] = 3'd2;
    run_song(1, 16, 2, 0);
    run_song(1, 16, 3, 0);
    rom_len[0] = 3'd4;
    run_song(1, 1, 3, 0);
    rom_len[0] = 3'd7;
    run_song(1, 64, 0, 0);

    // pause mid-PLAY at tick 2 of 4
    rom_len[0] = 3'd2;
    e = '0;
    e[49] = 1'b1; e[47:40] = 8'd1; e[39:20] = 20'(2 * TICK_DIV);
    exp_q.push_back(e);
    do_start(1, 16, 0);
    repeat (9) @(posedge clk);
    #1 pause = 1'b1;
    @(posedge clk);
    #1 pause_win = 1'b1; pause_hi = 0; pause_over = 0;
    repeat (49) @(posedge clk);
    #1 pause = 1'b0;
    @(posedge clk);
    #1 pause_win = 1'b0;
    chk("pause_sound_en_cycles", pause_hi, 0);
    chk("pause_over_pulses", pause_over, 0);
    wait_done();

    // abort inside note 0 gap, then abort with start together
    rom_len[0] = 3'd2; rom_len[1] = 3'd2;
    push_song(2, 16, 0);
    do_start(2, 16, 0);
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_idle_outputs("abort");
    @(posedge clk); #1 abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_done", done, 0);
    repeat (10) @(posedge clk);

    // empty track
    do_start(0, 16, 0);
    @(negedge clk);
    chk("track0_done", done, 1);
    chk("track0_busy", busy, 0);
    chk("track0_cnt", cnt, 0);
    repeat (4) @(posedge clk);

    // start while busy must be ignored
    rom_len[0] = 3'd1; rom_len[1] = 3'd0; rom_len[2] = 3'd2;
    run_song(3, 8, 0, 5);

    // reset mid-PLAY
    rom_len[0] = 3'd2;
    push_song(1, 16, 0);
    do_start(1, 16, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_idle_outputs("rst_mid_play");

    // randomized songs
    for (int s = 0; s < 12; s++) begin
      int trk, full, m;
      trk  = $urandom_range(1, 4);
      full = $urandom_range(1, 60);
      m    = $urandom_range(0, 3);
      for (int i = 0; i < trk; i++) rom_len[i] = 3'($urandom_range(0, 7));
      run_song(trk, full, m, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
